// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised sync FIFO.
package param_sync_fifo_pkg;

  // Pointer advance per accepted transfer.
  localparam int unsigned FIFO_PTR_INC = 1;

  // Ceiling log2 for address width derivation; v >= 2.
  function automatic int unsigned fifo_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  // DEPTH must be a power of two and at least 4.
  function automatic bit fifo_depth_legal(input int unsigned depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_sync_fifo_ptr.sv
// Wrapping FIFO pointer: one extra MSB distinguishes full from empty.
module param_sync_fifo_ptr
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Flush has priority over increment; wrap is the natural modulo of PTR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(FIFO_PTR_INC);
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill count, programmable thresholds, registered read
// data with valid strobe, sync flush and clearable sticky error flags.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = fifo_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W:0]   af_th,
  input  logic [ADDR_W:0]   ae_th,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  if (!fifo_depth_legal(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 4");
  end

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] mem [DEPTH];

  // Accepts use pre-edge flags, so full blocks writes even with a same-cycle read.
  assign we = wr_en & ~full;
  assign re = rd_en & ~empty;

  // Status derived combinationally from the pointer pair and live thresholds.
  assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty        = (wptr == rptr);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

  param_sync_fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (we),
    .ptr   (wptr)
  );

  param_sync_fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (re),
    .ptr   (rptr)
  );

  // Storage write; suppressed during reset and flush so no partial write lands.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && we) begin
      mem[wptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Registered read port: data holds its last value when nothing is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        rd_data <= mem[rptr[ADDR_W-1:0]];
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: reference queue model plus hand-computed vector tables.
module tb_param_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] af_th = 5'd12;
  logic [CW-1:0] ae_th = 5'd3;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .af_th        (af_th),
    .ae_th        (ae_th),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf, m_rv;
  logic [DW-1:0] m_rd;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          fl;
    logic          clr;
    int            cnt;
    logic          ovf;
    logic          unf;
    logic          rv;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t ta[5];
  vec_t tb[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic fl, input logic cl);
    bit mf, me;
    mf = (mq.size() == DEPTH);
    me = (mq.size() == 0);
    if (fl) begin
      mq.delete();
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = (w & mf) | (m_ovf & ~cl);
      m_unf = (r & me) | (m_unf & ~cl);
      m_rv  = r & !me;
      if (r && !me) m_rd = mq.pop_front();
      if (w && !mf) mq.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count),        32'(mq.size()));
    chk({tag, ".full"},  32'(full),         32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),        32'(mq.size() == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(mq.size() >= int'(af_th)));
    chk({tag, ".ae"},    32'(almost_empty), 32'(mq.size() <= int'(ae_th)));
    chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow),    32'(m_unf));
    chk({tag, ".rv"},    32'(rd_valid),     32'(m_rv));
    chk({tag, ".rd"},    32'(rd_data),      32'(m_rd));
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic fl, input logic cl);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = fl;
    clr_err = cl;
    @(posedge clk);
    #1;
    model_edge(w, d, r, fl, cl);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic step_chk(input logic w, input logic [DW-1:0] d, input logic r,
                          input logic fl, input logic cl, input string tag);
    step(w, d, r, fl, cl);
    check_model(tag);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    step(v.wr, v.d, v.rd, v.fl, v.clr);
    chk({tag, ".count"}, 32'(count),     32'(v.cnt));
    chk({tag, ".full"},  32'(full),      32'(v.cnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty),     32'(v.cnt == 0));
    chk({tag, ".ovf"},   32'(overflow),  32'(v.ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(v.unf));
    chk({tag, ".rv"},    32'(rd_valid),  32'(v.rv));
    chk({tag, ".rd"},    32'(rd_data),   32'(v.rdd));
  endtask

  initial begin
    // Full FIFO holding 0x80..0x8F: collisions with full, clears, set-beats-clear
    ta[0] = '{wr:1'b1, d:8'hEE, rd:1'b1, fl:1'b0, clr:1'b0, cnt:15, ovf:1'b1, unf:1'b0, rv:1'b1, rdd:8'h80};
    ta[1] = '{wr:1'b0, d:8'h00, rd:1'b0, fl:1'b0, clr:1'b1, cnt:15, ovf:1'b0, unf:1'b0, rv:1'b0, rdd:8'h80};
    ta[2] = '{wr:1'b1, d:8'hEF, rd:1'b0, fl:1'b0, clr:1'b0, cnt:16, ovf:1'b0, unf:1'b0, rv:1'b0, rdd:8'h80};
    ta[3] = '{wr:1'b1, d:8'hF0, rd:1'b0, fl:1'b0, clr:1'b1, cnt:16, ovf:1'b1, unf:1'b0, rv:1'b0, rdd:8'h80};
    ta[4] = '{wr:1'b0, d:8'h00, rd:1'b1, fl:1'b0, clr:1'b0, cnt:15, ovf:1'b1, unf:1'b0, rv:1'b1, rdd:8'h81};
    // Flush at count 9 with wr/rd asserted, then empty-side collision
    tb[0] = '{wr:1'b1, d:8'h77, rd:1'b1, fl:1'b1, clr:1'b0, cnt:0,  ovf:1'b0, unf:1'b0, rv:1'b0, rdd:8'h87};
    tb[1] = '{wr:1'b1, d:8'h11, rd:1'b1, fl:1'b0, clr:1'b0, cnt:1,  ovf:1'b0, unf:1'b1, rv:1'b0, rdd:8'h87};
    tb[2] = '{wr:1'b0, d:8'h00, rd:1'b1, fl:1'b0, clr:1'b0, cnt:0,  ovf:1'b0, unf:1'b1, rv:1'b1, rdd:8'h11};
    tb[3] = '{wr:1'b0, d:8'h00, rd:1'b0, fl:1'b0, clr:1'b1, cnt:0,  ovf:1'b0, unf:1'b0, rv:1'b0, rdd:8'h11};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    // 1: fill, then overflow attempt
    for (int i = 0; i < 16; i++) step_chk(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, $sformatf("t1_wr%0d", i));
    step_chk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, "t1_ovf");
    ae_th = 5'd16;
    #1;
    chk("t1_ae_th16", 32'(almost_empty), 32'd1);
    ae_th = 5'd3;

    // 2: drain in order, then underflow
    for (int i = 0; i < 16; i++) step_chk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("t2_rd%0d", i));
    step_chk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t2_unf");
    af_th = 5'd0;
    #1;
    chk("t2_af_th0", 32'(almost_full), 32'd1);
    af_th = 5'd12;
    step_chk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2_clr");

    // 3: half fill then streaming across pointer wrap
    for (int i = 0; i < 8; i++) step_chk(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, $sformatf("t3_fill%0d", i));
    for (int i = 0; i < 40; i++) step_chk(1'b1, 8'(8'h48 + i), 1'b1, 1'b0, 1'b0, $sformatf("t3_stream%0d", i));

    // 4/5: collisions, clears and flush
    step_chk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "t4_flush0");
    for (int i = 0; i < 16; i++) step_chk(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, $sformatf("t4_fill%0d", i));
    for (int i = 0; i < 5; i++) run_vec(ta[i], $sformatf("t4_vec%0d", i));
    for (int i = 0; i < 6; i++) step_chk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("t5_rd%0d", i));
    for (int i = 0; i < 4; i++) run_vec(tb[i], $sformatf("t5_vec%0d", i));

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step_chk(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0, $sformatf("t6_wr%0d", i));
    step_chk(1'b1, 8'h24, 1'b1, 1'b0, 1'b0, "t6_wrrd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("t6_async");
    wr_en   = 1'b1;
    wr_data = 8'h99;
    @(posedge clk);
    #1;
    check_model("t6_hold");
    wr_en = 1'b0;
    rst_n = 1'b1;
    #2;
    step_chk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t6_unf");
    step_chk(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "t6_wr");
    step_chk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t6_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
